// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC square-root sequencer: FSM encoding,
// hyperbolic repeat indices and iteration-schedule helpers.
package cordic_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_SCALE,
      S_OUT
   } state_e;

   // Hyperbolic CORDIC only converges if these shift indices run twice.
   localparam int REP_IDX_A = 4;
   localparam int REP_IDX_B = 13;
   localparam int REP_IDX_C = 40;

   // 1/K_h in Q2.14.
   localparam int DEF_INV_GAIN = 19784;
   localparam int GAIN_FRAC    = 14;

   function automatic logic is_repeat_idx(input int idx);
      return (idx == REP_IDX_A) || (idx == REP_IDX_B) || (idx == REP_IDX_C);
   endfunction

   function automatic int calc_steps(input int num_iter);
      int steps;
      steps = num_iter;
      if (num_iter >= REP_IDX_A) steps = steps + 1;
      if (num_iter >= REP_IDX_B) steps = steps + 1;
      if (num_iter >= REP_IDX_C) steps = steps + 1;
      return steps;
   endfunction

endpackage

// File: rtl/cordic_iter_schedule.sv
// Walks the hyperbolic shift schedule 1..NUM_ITER, issuing repeat indices
// twice, and flags the final step of the schedule.
module cordic_iter_schedule
   import cordic_pkg::*;
#(
   parameter int NUM_ITER = 12,
   parameter int ITW      = 10
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic           start_i,
   input  logic           advance_i,
   output logic [ITW-1:0] iteration_o,
   output logic           last_step_o
);

   localparam int           STEPS     = calc_steps(NUM_ITER);
   localparam logic [ITW:0] LAST_STEP = (ITW+1)'(STEPS - 1);

   logic [ITW-1:0] iter_q, iter_d;
   logic           rep_q, rep_d;
   logic [ITW:0]   step_q, step_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         iter_q <= ITW'(1);
         rep_q  <= 1'b0;
         step_q <= '0;
      end else begin
         iter_q <= iter_d;
         rep_q  <= rep_d;
         step_q <= step_d;
      end
   end

   always_comb begin
      iter_d = iter_q;
      rep_d  = rep_q;
      step_d = step_q;
      if (start_i) begin
         iter_d = ITW'(1);
         rep_d  = 1'b0;
         step_d = '0;
      end else if (advance_i) begin
         step_d = step_q + 1'b1;
         // rep_q marks that the first pass of a repeated index is done
         if (is_repeat_idx(int'(iter_q)) && !rep_q) begin
            rep_d = 1'b1;
         end else begin
            rep_d  = 1'b0;
            iter_d = iter_q + 1'b1;
         end
      end
   end

   assign iteration_o = iter_q;
   assign last_step_o = (step_q == LAST_STEP);

endmodule

// File: rtl/cordic_sqrt_sequencer.sv
// Drives a single-iteration hyperbolic-vectoring CORDIC core through the full
// schedule for one operand and returns gain-compensated sqrt(v).
module cordic_sqrt_sequencer
   import cordic_pkg::*;
#(
   parameter int IN_WIDTH            = 10,
   parameter int FRAC_BITS           = 8,
   parameter int OUT_WIDTH           = IN_WIDTH,
   parameter int CW                  = IN_WIDTH + 2,
   parameter int MAX_ITERATION_WIDTH = 10,
   parameter int NUM_ITER            = 12,
   parameter int INV_GAIN            = DEF_INV_GAIN
) (
   input  logic                              aclk,
   input  logic                              aresetn,
   input  logic [IN_WIDTH-1:0]               s_axis_tdata,
   input  logic                              s_axis_tvalid,
   output logic                              s_axis_tready,
   output logic [OUT_WIDTH-1:0]              m_axis_tdata,
   output logic                              m_axis_tvalid,
   input  logic                              m_axis_tready,
   output logic [2*CW+MAX_ITERATION_WIDTH-1:0] core_s_data,
   output logic                              core_s_valid,
   input  logic                              core_s_ready,
   input  logic [2*CW-1:0]                   core_m_data,
   input  logic                              core_m_valid,
   output logic                              core_m_ready
);

   localparam int                   PW      = CW + 16;
   localparam logic signed [CW-1:0] QUARTER = CW'(1 << (FRAC_BITS - 2));
   localparam logic signed [PW-1:0] GAIN    = PW'(INV_GAIN);
   localparam logic signed [PW-1:0] OUT_MAX = PW'((1 << OUT_WIDTH) - 1);

   state_e                         state_q, state_d;
   logic signed [CW-1:0]           x_q, x_d, y_q, y_d;
   logic [OUT_WIDTH-1:0]           tdata_q, tdata_d;
   logic                           in_hs, rsp_hs;
   logic [MAX_ITERATION_WIDTH-1:0] iteration;
   logic                           last_step;
   logic signed [CW-1:0]           v_ext;
   logic signed [PW-1:0]           prod, scaled;
   logic [OUT_WIDTH-1:0]           sat_val;

   assign v_ext  = $signed({{(CW-IN_WIDTH){1'b0}}, s_axis_tdata});
   assign in_hs  = (state_q == S_IDLE) && s_axis_tvalid;
   assign rsp_hs = (state_q == S_WAIT) && core_m_valid;

   cordic_iter_schedule #(
      .NUM_ITER (NUM_ITER),
      .ITW      (MAX_ITERATION_WIDTH)
   ) u_sched (
      .clk_i       (aclk),
      .rst_ni      (aresetn),
      .start_i     (in_hs),
      .advance_i   (rsp_hs),
      .iteration_o (iteration),
      .last_step_o (last_step)
   );

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         tdata_q <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         tdata_q <= tdata_d;
      end
   end

   // Handshake outputs are pure state decodes, so a request is dropped the
   // cycle after it is accepted and never re-presented to the core.
   always_comb begin
      state_d       = state_q;
      s_axis_tready = 1'b0;
      core_s_valid  = 1'b0;
      core_m_ready  = 1'b0;
      m_axis_tvalid = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid) state_d = S_ISSUE;
         end
         S_ISSUE: begin
            core_s_valid = 1'b1;
            if (core_s_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            core_m_ready = 1'b1;
            if (core_m_valid) state_d = last_step ? S_SCALE : S_ISSUE;
         end
         S_SCALE: begin
            state_d = S_OUT;
         end
         S_OUT: begin
            m_axis_tvalid = 1'b1;
            if (m_axis_tready) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      prod   = PW'(x_q) * GAIN;
      scaled = prod >>> GAIN_FRAC;
      if (scaled < 0) begin
         sat_val = '0;
      end else if (scaled > OUT_MAX) begin
         sat_val = '1;
      end else begin
         sat_val = scaled[OUT_WIDTH-1:0];
      end
   end

   always_comb begin
      x_d     = x_q;
      y_d     = y_q;
      tdata_d = tdata_q;
      if (in_hs) begin
         x_d = v_ext + QUARTER;
         y_d = v_ext - QUARTER;
      end else if (rsp_hs) begin
         x_d = $signed(core_m_data[2*CW-1:CW]);
         y_d = $signed(core_m_data[CW-1:0]);
      end
      if (state_q == S_SCALE) tdata_d = sat_val;
   end

   assign core_s_data  = core_s_valid ? {x_q, y_q, iteration} : '0;
   assign m_axis_tdata = tdata_q;

endmodule

// File: tb/tb_cordic_sqrt_sequencer.sv
// Self-checking bench: behavioural CORDIC core model, scoreboard of expected
// square roots, directed latency / backpressure / stall / reset scenarios.
module tb_cordic_sqrt_sequencer;

   localparam int IN_W   = 10;
   localparam int OUT_W  = 10;
   localparam int CW     = 12;
   localparam int ITW    = 10;
   localparam int CORE_W = 2*CW + ITW;

   logic              aclk;
   logic              aresetn;
   logic [IN_W-1:0]   s_axis_tdata;
   logic              s_axis_tvalid;
   logic              s_axis_tready;
   logic [OUT_W-1:0]  m_axis_tdata;
   logic              m_axis_tvalid;
   logic              m_axis_tready;
   logic [CORE_W-1:0] core_s_data;
   logic              core_s_valid;
   logic              core_s_ready;
   logic [2*CW-1:0]   core_m_data;
   logic              core_m_valid;
   logic              core_m_ready;

   typedef struct {
      int exp_val;
      int ideal;
      bit tol_en;
   } sb_item_t;

   sb_item_t sb[$];
   int       iter_log[$];
   int       n_assert = 0;
   int       n_fail   = 0;
   int       cyc = 0;
   int       c0 = 0;
   int       acc_cnt = 0;
   int       acc_base = 0;
   int       stall_cycles = 0;
   int       stall_base = 0;
   bit       stall_en = 0;
   int       xfer_cnt = 0;
   logic     hs_q = 1'b0;
   logic [OUT_W-1:0] hs_data = '0;
   logic     acc_prev = 1'b0;
   int       exp_iter[13] = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12};

   cordic_sqrt_sequencer dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .core_s_data   (core_s_data),
      .core_s_valid  (core_s_valid),
      .core_s_ready  (core_s_ready),
      .core_m_data   (core_m_data),
      .core_m_valid  (core_m_valid),
      .core_m_ready  (core_m_ready)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_tol(input string tag, input int obs, input int ideal);
      int d;
      d = obs - ideal;
      if (d < 0) d = -d;
      n_assert++;
      assert ((d <= 2) === 1'b1) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d+-2", tag, obs, ideal);
      end
   endtask

   // Core arithmetic: shifts truncate toward zero so residual -1 values do not drift X.
   function automatic int tz_shift(input int a, input int s);
      return (a < 0) ? -((-a) >>> s) : (a >>> s);
   endfunction

   function automatic void cstep(input int x, input int y, input int it, output int xo, output int yo);
      int sx, sy;
      sx = tz_shift(y, it);
      sy = tz_shift(x, it);
      if (y >= 0) begin
         xo = x - sx;
         yo = y - sy;
      end else begin
         xo = x + sx;
         yo = y + sy;
      end
   endfunction

   function automatic logic [2*CW-1:0] core_calc(input logic [CORE_W-1:0] req);
      logic signed [CW-1:0] fx, fy;
      int xo, yo;
      fx = req[CORE_W-1 -: CW];
      fy = req[CORE_W-CW-1 -: CW];
      cstep(int'(fx), int'(fy), int'(req[ITW-1:0]), xo, yo);
      return {xo[CW-1:0], yo[CW-1:0]};
   endfunction

   function automatic int ref_model(input int v);
      int x, y, xo, yo, p, r;
      x = v + 64;
      y = v - 64;
      for (int it = 1; it <= 12; it++) begin
         cstep(x, y, it, xo, yo);
         x = xo;
         y = yo;
         if (it == 4 || it == 13 || it == 40) begin
            cstep(x, y, it, xo, yo);
            x = xo;
            y = yo;
         end
      end
      p = x * 19784;
      r = p >>> 14;
      if (r < 0) r = 0;
      else if (r > 1023) r = 1023;
      return r;
   endfunction

   assign core_s_ready = !(stall_en && (acc_cnt - acc_base) == 5 && (stall_cycles - stall_base) < 5);

   // Core model: one-cycle latency, result held until the sequencer takes it.
   always @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         core_m_valid <= 1'b0;
         core_m_data  <= '0;
      end else begin
         if (core_m_valid && core_m_ready) core_m_valid <= 1'b0;
         if (core_s_valid && core_s_ready) begin
            core_m_valid <= 1'b1;
            core_m_data  <= core_calc(core_s_data);
         end
      end
   end

   always @(posedge aclk) begin
      cyc      <= cyc + 1;
      hs_q     <= aresetn && m_axis_tvalid && m_axis_tready;
      hs_data  <= m_axis_tdata;
      acc_prev <= aresetn && core_s_valid && core_s_ready;
      if (aresetn && core_s_valid && core_s_ready) begin
         acc_cnt <= acc_cnt + 1;
         iter_log.push_back(int'(core_s_data[ITW-1:0]));
      end
      if (aresetn && core_s_valid && !core_s_ready) stall_cycles <= stall_cycles + 1;
   end

   always @(negedge aclk) begin
      if (hs_q) begin
         xfer_cnt <= xfer_cnt + 1;
         if (sb.size() == 0) begin
            chk("sb_underflow", 40'(sb.size()), 40'd1);
         end else begin
            $display("result: tdata=%0d expected=%0d", hs_data, sb[0].exp_val);
            chk("result", 40'(hs_data), 40'(sb[0].exp_val));
            if (sb[0].tol_en) chk_tol("accuracy", int'(hs_data), sb[0].ideal);
            void'(sb.pop_front());
         end
      end
      if (acc_prev) chk("req_valid_drop", 40'(core_s_valid), 40'd0);
   end

   task automatic check_rst(input string p);
      chk({p, "_s_tready"}, 40'(s_axis_tready), 40'd1);
      chk({p, "_m_tvalid"}, 40'(m_axis_tvalid), 40'd0);
      chk({p, "_m_tdata"}, 40'(m_axis_tdata), 40'd0);
      chk({p, "_core_s_valid"}, 40'(core_s_valid), 40'd0);
      chk({p, "_core_m_ready"}, 40'(core_m_ready), 40'd0);
      chk({p, "_core_s_data"}, 40'(core_s_data), 40'd0);
   endtask

   task automatic send(input int v, input int ideal, input bit tol);
      int n;
      n = 0;
      @(negedge aclk);
      while (s_axis_tready !== 1'b1 && n < 100) begin
         @(negedge aclk);
         n++;
      end
      if (s_axis_tready !== 1'b1) chk("send_tready_timeout", 40'(s_axis_tready), 40'd1);
      s_axis_tdata  = v[IN_W-1:0];
      s_axis_tvalid = 1'b1;
      @(posedge aclk);
      #1;
      c0 = cyc;
      s_axis_tvalid = 1'b0;
      sb.push_back('{exp_val: ref_model(v), ideal: ideal, tol_en: tol});
      $display("send: v=%0d expected=%0d", v, ref_model(v));
   endtask

   task automatic wait_valid(input string tag, input int exp_lat);
      int n;
      n = 0;
      while (m_axis_tvalid !== 1'b1 && n < 400) begin
         @(negedge aclk);
         n++;
      end
      if (m_axis_tvalid !== 1'b1) chk({tag, "_timeout"}, 40'(m_axis_tvalid), 40'd1);
      chk({tag, "_latency"}, 40'(cyc - c0), 40'(exp_lat));
   endtask

   task automatic drain(input string tag);
      int xb;
      xb = xfer_cnt;
      @(posedge aclk);
      #1;
      chk({tag, "_tvalid_drop"}, 40'(m_axis_tvalid), 40'd0);
      chk({tag, "_s_tready_back"}, 40'(s_axis_tready), 40'd1);
      @(negedge aclk);
      #1;
      chk({tag, "_one_xfer"}, 40'(xfer_cnt - xb), 40'd1);
   endtask

   initial begin
      int base, m, xb, n;
      logic [CORE_W-1:0] held_req;
      logic [OUT_W-1:0]  held_out;

      aresetn       = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b1;
      repeat (2) @(negedge aclk);
      check_rst("por");
      aresetn = 1'b1;
      @(negedge aclk);

      // v = 1.0: latency and iteration schedule on the core port
      base = iter_log.size();
      send(256, 256, 1'b1);
      wait_valid("v256", 27);
      drain("v256");
      chk("iter_count", 40'(iter_log.size() - base), 40'd13);
      for (int k = 0; k < 13; k++) begin
         chk($sformatf("iter_field_%0d", k), 40'(iter_log[base + k]), 40'(exp_iter[k]));
      end

      send(64, 128, 1'b1);
      wait_valid("v64", 27);
      drain("v64");

      send(512, 362, 1'b1);
      wait_valid("v512", 27);
      drain("v512");

      send(0, 0, 1'b0);
      wait_valid("v0", 27);
      drain("v0");

      send(1023, 0, 1'b0);
      wait_valid("v1023", 27);
      drain("v1023");

      // Downstream backpressure for 20 cycles
      m_axis_tready = 1'b0;
      send(100, 160, 1'b0);
      wait_valid("bp", 27);
      held_out = m_axis_tdata;
      xb = xfer_cnt;
      repeat (20) begin
         @(negedge aclk);
         chk("bp_tdata_stable", 40'(m_axis_tdata), 40'(held_out));
         chk("bp_tvalid_held", 40'(m_axis_tvalid), 40'd1);
         chk("bp_s_tready", 40'(s_axis_tready), 40'd0);
         chk("bp_core_s_valid", 40'(core_s_valid), 40'd0);
      end
      chk("bp_no_early_xfer", 40'(xfer_cnt - xb), 40'd0);
      m_axis_tready = 1'b1;
      drain("bp");
      @(negedge aclk);
      #1;
      chk("bp_no_dup_xfer", 40'(xfer_cnt - xb), 40'd1);

      // Core stall of 5 cycles on step 6
      acc_base   = acc_cnt;
      stall_base = stall_cycles;
      stall_en   = 1'b1;
      send(256, 256, 1'b1);
      n = 0;
      while (!(core_s_valid === 1'b1 && core_s_ready === 1'b0) && n < 100) begin
         @(negedge aclk);
         n++;
      end
      held_req = core_s_data;
      chk("stall_iter_field", 40'(held_req[ITW-1:0]), 40'd5);
      m = 0;
      while (core_s_ready === 1'b0 && m < 20) begin
         chk("stall_valid_held", 40'(core_s_valid), 40'd1);
         chk("stall_data_stable", 40'(core_s_data), 40'(held_req));
         @(negedge aclk);
         m++;
      end
      chk("stall_len", 40'(m), 40'd5);
      wait_valid("stall", 32);
      drain("stall");
      stall_en = 1'b0;

      // Asynchronous reset while waiting on step 7
      acc_base = acc_cnt;
      xb = xfer_cnt;
      send(400, 0, 1'b0);
      n = 0;
      while (!((acc_cnt - acc_base) == 7 && core_m_ready === 1'b1) && n < 100) begin
         @(negedge aclk);
         n++;
      end
      chk("arst_reached_wait", 40'(core_m_ready), 40'd1);
      #2;
      aresetn = 1'b0;
      #1;
      check_rst("arst");
      void'(sb.pop_front());
      @(negedge aclk);
      aresetn = 1'b1;
      send(144, 192, 1'b1);
      wait_valid("v144", 27);
      drain("v144");
      chk("arst_no_stray_xfer", 40'(xfer_cnt - xb), 40'd1);

      repeat (3) @(negedge aclk);
      chk("sb_empty", 40'(sb.size()), 40'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
